// File: rtl/led_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_pkg
// Description : Shared types and helpers for the LED pattern generator.
//               Holds the channel mode encoding, the mode field width and
//               the prescaler divide computation.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pattern_pkg;

    // Width of the mode field on the configuration port.
    localparam int MODE_W = 3;

    // Channel modes; encodings 5..7 are reserved and always rejected.
    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_PWM     = 3'd3,
        MODE_BREATHE = 3'd4
    } mode_e;

    // Clock cycles per prescaler tick.
    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_channel.sv
`default_nettype none
// ============================================================================
// Module      : led_channel
// Description : One LED channel: configuration registers, tick counter and
//               OFF/ON/BLINK/PWM mode logic, plus BREATHE level/direction
//               registers when LED_PATTERN_BREATHE_EN is defined.
// Ports       : clk, rst_n     - clock, synchronous active-low reset
//               i_tick         - shared prescaler tick (one-cycle pulse)
//               i_phase        - shared free-running duty phase
//               i_wr           - write strobe for this channel (wins over tick)
//               i_mode/i_period/i_duty - values loaded on i_wr
//               o_led          - registered LED output
// Revision    : 1.0 - initial release
// ============================================================================
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int    CNT_W      = 16,
    parameter int    DUTY_W     = 8,
    parameter mode_e RST_MODE   = MODE_OFF,
    parameter int    RST_PERIOD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_tick,
    input  logic [DUTY_W-1:0] i_phase,
    input  logic              i_wr,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [CNT_W-1:0]  i_period,
    input  logic [DUTY_W-1:0] i_duty,
    output logic              o_led
);

    mode_e             r_mode;
    logic [CNT_W-1:0]  r_period;
    logic [DUTY_W-1:0] r_duty;
    logic [CNT_W-1:0]  r_tcnt;
    logic              r_led;

    logic [CNT_W-1:0]  w_per_last;
    logic [CNT_W-1:0]  w_tcnt_nxt;
    logic              w_step;
    logic              w_led_nxt;

`ifdef LED_PATTERN_BREATHE_EN
    localparam logic [DUTY_W-1:0] C_LVL_MAX = '1;

    logic [DUTY_W-1:0] r_lvl;
    logic              r_dir;   // 0 = rising, 1 = falling
`endif

    // A period of 0 behaves as 1, so its last count is also 0.
    assign w_per_last = (r_period == '0) ? '0 : (r_period - 1'b1);

    always_comb begin
        w_tcnt_nxt = r_tcnt;
        w_step     = 1'b0;
        w_led_nxt  = r_led;
        if (i_tick && ((r_mode == MODE_BLINK) || (r_mode == MODE_BREATHE))) begin
            if (r_tcnt == w_per_last) begin
                w_tcnt_nxt = '0;
                w_step     = 1'b1;
            end else begin
                w_tcnt_nxt = r_tcnt + 1'b1;
            end
        end
        case (r_mode)
            MODE_OFF:     w_led_nxt = 1'b0;
            MODE_ON:      w_led_nxt = 1'b1;
            MODE_BLINK:   w_led_nxt = r_led ^ w_step;
            MODE_PWM:     w_led_nxt = (i_phase < r_duty);
`ifdef LED_PATTERN_BREATHE_EN
            MODE_BREATHE: w_led_nxt = (i_phase < r_lvl);
`endif
            default:      w_led_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode   <= RST_MODE;
            r_period <= CNT_W'(RST_PERIOD);
            r_duty   <= '0;
            r_tcnt   <= '0;
            r_led    <= 1'b0;
        end else if (i_wr) begin
            // A write restarts the pattern and swallows any coincident tick.
            r_mode   <= mode_e'(i_mode);
            r_period <= i_period;
            r_duty   <= i_duty;
            r_tcnt   <= '0;
            r_led    <= 1'b0;
        end else begin
            r_tcnt   <= w_tcnt_nxt;
            r_led    <= w_led_nxt;
        end
    end

`ifdef LED_PATTERN_BREATHE_EN
    // Triangle wave: the direction flips on the step that lands on an end
    // value, so neither end is held longer than one step interval.
    always_ff @(posedge clk) begin
        if (!rst_n || i_wr) begin
            r_lvl <= '0;
            r_dir <= 1'b0;
        end else if (w_step && (r_mode == MODE_BREATHE)) begin
            if (!r_dir) begin
                r_lvl <= r_lvl + 1'b1;
                if (r_lvl == (C_LVL_MAX - 1'b1)) begin
                    r_dir <= 1'b1;
                end
            end else begin
                r_lvl <= r_lvl - 1'b1;
                if (r_lvl == DUTY_W'(1)) begin
                    r_dir <= 1'b0;
                end
            end
        end
    end
`endif

    assign o_led = r_led;

endmodule
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_gen
// Description : Multi-channel LED pattern generator. A shared prescaler makes
//               the tick, a shared phase counter drives PWM/BREATHE, and a
//               valid/ready write port configures each channel. Channel 0
//               blinks at RST_PERIOD out of reset.
//               Build option: define LED_PATTERN_BREATHE_EN to implement
//               mode 4 (BREATHE); otherwise mode 4 is rejected as reserved.
// Ports       : clk, rst_n  - clock, synchronous active-low reset
//               cfg_valid / cfg_ready - write handshake (ready is constant 1
//                              after reset)
//               cfg_ch, cfg_mode, cfg_period, cfg_duty - write payload
//               cfg_err     - one-cycle pulse after a rejected write
//               led         - registered LED outputs
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int CLK_HZ     = 5_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int DUTY_W     = 8,
    parameter int RST_PERIOD = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [DUTY_W-1:0] cfg_duty,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] led
);

    localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int PRE_W = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("led_pattern_gen: CLK_HZ/TICK_HZ must be at least 2");
        end
        if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_num_ch_check
            $error("led_pattern_gen: NUM_CH must be in 1..16");
        end
    endgenerate

    logic [PRE_W-1:0]  r_pre;
    logic [DUTY_W-1:0] r_phase;
    logic              r_ready;
    logic              r_err;

    logic              w_tick;
    logic              w_hs;
    logic              w_ch_ok;
    logic              w_mode_ok;
    logic              w_wr_ok;
    logic [NUM_CH-1:0] w_led;

    assign w_tick = (r_pre == C_PRE_LAST);

    // Prescaler and phase are free-running; writes never restart them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_phase <= '0;
        end else begin
            r_pre   <= w_tick ? '0 : (r_pre + 1'b1);
            r_phase <= r_phase + 1'b1;
        end
    end

    assign w_hs    = cfg_valid && r_ready;
    assign w_ch_ok = ({1'b0, cfg_ch} < 5'(NUM_CH));

    always_comb begin
        w_mode_ok = 1'b0;
        case (cfg_mode)
            MODE_OFF, MODE_ON, MODE_BLINK, MODE_PWM: w_mode_ok = 1'b1;
`ifdef LED_PATTERN_BREATHE_EN
            MODE_BREATHE: w_mode_ok = 1'b1;
`endif
            default: w_mode_ok = 1'b0;
        endcase
    end

    assign w_wr_ok = w_hs && w_ch_ok && w_mode_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_err   <= w_hs && !(w_ch_ok && w_mode_ok);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            led_channel #(
                .CNT_W      (CNT_W),
                .DUTY_W     (DUTY_W),
                .RST_MODE   ((gi == 0) ? MODE_BLINK : MODE_OFF),
                .RST_PERIOD ((gi == 0) ? RST_PERIOD : 1)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_tick   (w_tick),
                .i_phase  (r_phase),
                .i_wr     (w_wr_ok && (cfg_ch == 4'(gi))),
                .i_mode   (cfg_mode),
                .i_period (cfg_period),
                .i_duty   (cfg_duty),
                .o_led    (w_led[gi])
            );
        end
    endgenerate

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign led       = w_led;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_led_pattern_gen
// Description : Self-checking bench for led_pattern_gen (DIV=10, 4 channels).
//               Expected LED values come from an arithmetic model indexed by
//               the number of clock edges since reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    localparam int C_DIV     = 10;
    localparam int C_NCH     = 4;
    localparam int C_RST_PER = 5;
`ifdef LED_PATTERN_BREATHE_EN
    localparam bit C_BREATHE = 1'b1;
`else
    localparam bit C_BREATHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [3:0]  cfg_ch = '0;
    logic [2:0]  cfg_mode = '0;
    logic [15:0] cfg_period = '0;
    logic [7:0]  cfg_duty = '0;
    logic        cfg_err;
    logic [3:0]  led;

    int checks = 0;
    int failures = 0;

    // Edge index since reset release: edge 1 is the first edge with rst_n=1.
    int unsigned kcnt = 0;

    int          m_mode [C_NCH];
    int          m_per  [C_NCH];
    int          m_duty [C_NCH];
    int unsigned m_w    [C_NCH];

    led_pattern_gen #(
        .CLK_HZ     (1000),
        .TICK_HZ    (100),
        .NUM_CH     (C_NCH),
        .CNT_W      (16),
        .DUTY_W     (8),
        .RST_PERIOD (C_RST_PER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_err    (cfg_err),
        .led        (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) kcnt <= 0;
        else        kcnt <= kcnt + 1;
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int c = 0; c < C_NCH; c++) begin
            m_mode[c] = (c == 0) ? 2 : 0;
            m_per[c]  = (c == 0) ? C_RST_PER : 1;
            m_duty[c] = 0;
            m_w[c]    = 0;
        end
    endfunction

    // Ticks fall on edges that are multiples of DIV; count those in (w, k].
    function automatic int unsigned ticks_between(input int unsigned w, input int unsigned k);
        return (k / C_DIV) - (w / C_DIV);
    endfunction

    function automatic int lvl_at(input int unsigned s);
        int m;
        m = int'(s % 510);
        return (m <= 255) ? m : (510 - m);
    endfunction

    function automatic logic exp_led(input int ch, input int unsigned k);
        int unsigned w;
        int p;
        w = m_w[ch];
        p = (m_per[ch] == 0) ? 1 : m_per[ch];
        if (k <= w) return 1'b0;
        case (m_mode[ch])
            1:       return 1'b1;
            2:       return ((ticks_between(w, k) / p) % 2) == 1;
            3:       return int'((k - 1) % 256) < m_duty[ch];
            4:       return int'((k - 1) % 256) < lvl_at(ticks_between(w, k - 1) / p);
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic run_check(input int n);
        logic [3:0] e;
        repeat (n) begin
            @(negedge clk);
            for (int c = 0; c < C_NCH; c++) e[c] = exp_led(c, kcnt);
            checks++;
            if (led !== e) begin
                failures++;
                $display("FAIL led_model k=%0d actual=%b expected=%b", kcnt, led, e);
            end
        end
    endtask

    task automatic do_write(input int ch, input int mode, input int per, input int duty);
        bit ok;
        @(negedge clk);
        cfg_valid  = 1'b1;
        cfg_ch     = 4'(ch);
        cfg_mode   = 3'(mode);
        cfg_period = 16'(per);
        cfg_duty   = 8'(duty);
        ok = (ch < C_NCH) && ((mode <= 3) || ((mode == 4) && C_BREATHE));
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_ready actual=%b expected=1", cfg_ready);
        end
        if (ok) begin
            m_mode[ch] = mode;
            m_per[ch]  = per;
            m_duty[ch] = duty;
            m_w[ch]    = kcnt;
        end
        checks++;
        if (cfg_err !== !ok) begin
            failures++;
            $display("FAIL cfg_err_pulse ch=%0d mode=%0d actual=%b expected=%b", ch, mode, cfg_err, !ok);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cfg_err !== 1'b0) begin
            failures++;
            $display("FAIL cfg_err_width actual=%b expected=0", cfg_err);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cfg_ready, cfg_err, led} !== 6'b0) begin
            failures++;
            $display("FAIL reset_state actual=%b expected=000000", {cfg_ready, cfg_err, led});
        end
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_release actual=%b expected=1", cfg_ready);
        end
        run_check(160);
    endtask

    task automatic test_blink();
        int unsigned w;
        int d;
        run_check($urandom_range(1, 10));
        do_write(1, 2, 3, 0);
        w = m_w[1];
        d = -1;
        for (int i = 0; i < 40 && d < 0; i++) begin
            @(negedge clk);
            if (led[1] === 1'b1) d = int'(kcnt - w);
        end
        checks++;
        if (d < 21 || d > 30) begin
            failures++;
            $display("FAIL blink_first_toggle delay=%0d expected=21..30", d);
        end
        run_check(100);
    endtask

    task automatic test_pwm();
        int hi;
        int duties[3];
        duties[0] = 64;
        duties[1] = 0;
        duties[2] = 255;
        for (int j = 0; j < 3; j++) begin
            do_write(2, 3, 0, duties[j]);
            run_check(3);
            hi = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                if (led[2] === 1'b1) hi++;
            end
            checks++;
            if (hi != duties[j]) begin
                failures++;
                $display("FAIL pwm_high_count duty=%0d actual=%0d expected=%0d", duties[j], hi, duties[j]);
            end
        end
        do_write(2, 3, 0, $urandom_range(1, 254));
        run_check(300);
    endtask

    task automatic test_reject();
        do_write(5, $urandom_range(0, 3), 2, 10);
        run_check(30);
        do_write(1, 6, 2, 10);
        run_check(30);
        do_write(2, 7, 2, 10);
        run_check(30);
        if (!C_BREATHE) begin
            do_write(0, 4, 1, 0);
            run_check(30);
        end
    endtask

    task automatic test_tick_collision();
        // Bounded by DIV cycles: land the write on an edge that carries a tick.
        for (int i = 0; i < C_DIV && (kcnt % C_DIV) != C_DIV - 2; i++) @(negedge clk);
        do_write(3, 2, 1, 0);
        run_check(60);
        for (int i = 0; i < C_DIV && (kcnt % C_DIV) != C_DIV - 2; i++) @(negedge clk);
        do_write(1, 2, 2, 0);
        run_check(80);
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (led[0] !== 1'b1 && n < 120) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (led[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_precondition led0=%b expected=1", led[0]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({cfg_ready, cfg_err, led} !== 6'b0) begin
            failures++;
            $display("FAIL mid_reset_state actual=%b expected=000000", {cfg_ready, cfg_err, led});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_check(120);
    endtask

    task automatic test_breathe();
        if (C_BREATHE) begin
            do_write(3, 4, 1, 0);
            run_check(5300);
            do_write(2, 4, 0, 0);
            run_check(400);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            do_write($urandom_range(0, 5), $urandom_range(0, 7),
                     $urandom_range(0, 4), $urandom_range(0, 255));
            run_check($urandom_range(5, 80));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_blink();
        test_pwm();
        test_reject();
        test_tick_collision();
        test_reset_mid();
        test_breathe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
